uart_tx_scheduler: RTL and testbench

//   Shares one UART transmitter between N_REQ byte producers using round-robin arbitration.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rr_pick.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 139 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduler: FSM state encoding and default
// baud/frame constants used by the scheduler and its testbench.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_GUARD = 2'd3
    } state_e;

    // Guard and timeout are counted in oversample ticks, 16 per bit period.
    localparam int OVERSAMPLE        = 16;
    localparam int DEF_N_REQ         = 3;
    localparam int DEF_DATA_BITS     = 8;
    localparam int DEF_GUARD_TICKS   = OVERSAMPLE;
    localparam int DEF_TIMEOUT_TICKS = 256;
    localparam int DEF_CNT_W         = 9;

    function automatic logic state_is_busy(input state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: searches ptr+1, ptr+2, ... (mod N_REQ) and
// returns the first asserted request index.
module uart_rr_pick #(
    parameter int N_REQ = 3,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_winner
);

    // Scan from the farthest candidate down to the nearest so the nearest hit wins.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand     = '0;
        o_valid  = |i_req;
        o_winner = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(i_ptr) + i) % N_REQ);
            if (i_req[cand]) begin
                o_winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers.
// Each frame: capture byte, pulse start, wait for done (with timeout), then a guard gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int GUARD_TICKS   = DEF_GUARD_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_tick,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*DATA_BITS-1:0] i_data,
    output logic [N_REQ-1:0]           o_ack,
    output logic                       o_tx_start,
    output logic [DATA_BITS-1:0]       o_tx_data,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id,
    output logic                       o_timeout
);

    localparam int ID_W = $clog2(N_REQ);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;

    logic                 pick_valid;
    logic [ID_W-1:0]      pick_id;
    logic [CNT_W-1:0]     cnt_inc;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (ptr_q),
        .o_valid  (pick_valid),
        .o_winner (pick_id)
    );

    // Saturating tick count; only SEND and GUARD consume it.
    assign cnt_inc = (i_tick && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        ack_d     = '0;
        start_d   = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d        = ST_LOAD;
                    grant_d        = pick_id;
                    ptr_d          = pick_id;
                    data_d         = i_data[int'(pick_id)*DATA_BITS +: DATA_BITS];
                    ack_d[pick_id] = 1'b1;
                    start_d        = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_SEND;
                cnt_d   = '0;
            end
            ST_SEND: begin
                cnt_d = cnt_inc;
                if (i_tx_done) begin
                    cnt_d   = '0;
                    state_d = (GUARD_TICKS == 0) ? ST_IDLE : ST_GUARD;
                end else if ((TIMEOUT_TICKS != 0) && (cnt_inc == CNT_W'(TIMEOUT_TICKS))) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = (GUARD_TICKS == 0) ? ST_IDLE : ST_GUARD;
                end
            end
            ST_GUARD: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(GUARD_TICKS)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = state_is_busy(state_d);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= ID_W'(N_REQ - 1);
            grant_q   <= '0;
            data_q    <= '0;
            ack_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;
    assign o_busy     = busy_q;
    assign o_grant_id = grant_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: three instances cover default timing,
// a short timeout and a zero guard gap; a monitor pops expected grants on each start.
module tb_uart_tx_scheduler;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [2:0]  req_a, req_b, req_c;
    logic [23:0] data_a, data_b, data_c;
    logic        done_a, done_b, done_c;
    logic [2:0]  ack_a, ack_b, ack_c;
    logic        start_a, start_b, start_c;
    logic [7:0]  txd_a, txd_b, txd_c;
    logic        busy_a, busy_b, busy_c;
    logic [1:0]  gid_a, gid_b, gid_c;
    logic        to_a, to_b, to_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler u_a (
        .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_req(req_a), .i_data(data_a),
        .o_ack(ack_a), .o_tx_start(start_a), .o_tx_data(txd_a), .i_tx_done(done_a),
        .o_busy(busy_a), .o_grant_id(gid_a), .o_timeout(to_a)
    );

    uart_tx_scheduler #(.GUARD_TICKS(2), .TIMEOUT_TICKS(4)) u_b (
        .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_req(req_b), .i_data(data_b),
        .o_ack(ack_b), .o_tx_start(start_b), .o_tx_data(txd_b), .i_tx_done(done_b),
        .o_busy(busy_b), .o_grant_id(gid_b), .o_timeout(to_b)
    );

    uart_tx_scheduler #(.GUARD_TICKS(0)) u_c (
        .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_req(req_c), .i_data(data_c),
        .o_ack(ack_c), .o_tx_start(start_c), .o_tx_data(txd_c), .i_tx_done(done_c),
        .o_busy(busy_c), .o_grant_id(gid_c), .o_timeout(to_c)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic monitor_check(input int w, input logic st, input logic [1:0] gid,
                                 input logic [7:0] txd, input logic [2:0] ack);
        exp_t  e;
        logic  found;
        string tag;
        found = 1'b0;
        e     = '0;
        tag   = (w == 0) ? "a" : (w == 1) ? "b" : "c";
        case (w)
            0:       if (q_a.size() > 0) begin e = q_a.pop_front(); found = 1'b1; end
            1:       if (q_b.size() > 0) begin e = q_b.pop_front(); found = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); found = 1'b1; end
        endcase
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s_unexpected_grant: got ack=0x%0h start=%0b, expected no grant", tag, ack, st);
        end else begin
            check_output($sformatf("%s_start", tag), 32'(st), 32'd1);
            check_output($sformatf("%s_grant_id", tag), 32'(gid), 32'(e.id));
            check_output($sformatf("%s_tx_data", tag), 32'(txd), 32'(e.data));
            check_output($sformatf("%s_ack", tag), 32'(ack), 32'(3'b001 << e.id));
        end
    endtask

    // Monitor: any start or ack consumes the next expected grant of that instance.
    always @(negedge clk) begin
        if (start_a || (ack_a != 3'b000)) monitor_check(0, start_a, gid_a, txd_a, ack_a);
        if (start_b || (ack_b != 3'b000)) monitor_check(1, start_b, gid_b, txd_b, ack_b);
        if (start_c || (ack_c != 3'b000)) monitor_check(2, start_c, gid_c, txd_c, ack_c);
    end

    function automatic logic start_of(input int w);
        case (w)
            0:       return start_a;
            1:       return start_b;
            default: return start_c;
        endcase
    endfunction

    task automatic apply_stimulus(input int w, input logic [2:0] req, input logic [23:0] data);
        case (w)
            0:       begin req_a = req; data_a = data; end
            1:       begin req_b = req; data_b = data; end
            default: begin req_c = req; data_c = data; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic give_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic pulse_done(input int w);
        case (w)
            0:       done_a = 1'b1;
            1:       done_b = 1'b1;
            default: done_c = 1'b1;
        endcase
        step();
        done_a = 1'b0;
        done_b = 1'b0;
        done_c = 1'b0;
    endtask

    task automatic wait_start(input int w, input int max_cyc, input string name);
        int n;
        n = 0;
        while (!start_of(w) && n < max_cyc) begin
            step();
            n++;
        end
        check_output(name, 32'(start_of(w)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1;
        rst_n  = 1'b0;
        tick   = 1'b0;
        req_a  = '0; req_b = '0; req_c = '0;
        data_a = '0; data_b = '0; data_c = '0;
        done_a = 1'b0; done_b = 1'b0; done_c = 1'b0;
        repeat (3) step();

        check_output("rst_busy",    32'(busy_a),  32'd0);
        check_output("rst_start",   32'(start_a), 32'd0);
        check_output("rst_ack",     32'(ack_a),   32'd0);
        check_output("rst_grant",   32'(gid_a),   32'd0);
        check_output("rst_txdata",  32'(txd_a),   32'd0);
        check_output("rst_timeout", 32'(to_a),    32'd0);
        rst_n = 1'b1;

        // Single request from requester 1, then done and a full 16-tick guard.
        apply_stimulus(0, 3'b010, {8'h33, 8'hA5, 8'h11});
        q_a.push_back('{id: 2'd1, data: 8'hA5});
        wait_start(0, 10, "t1_start_seen");
        apply_stimulus(0, 3'b000, {8'h33, 8'hA5, 8'h11});
        step();
        check_output("t1_busy_send", 32'(busy_a), 32'd1);
        pulse_done(0);
        give_ticks(15);
        check_output("t1_busy_guard15", 32'(busy_a), 32'd1);
        give_ticks(1);
        check_output("t1_idle_after_guard", 32'(busy_a), 32'd0);

        // All requesters high from reset: grants 0,1,2,0.
        step();
        rst_n = 1'b0;
        apply_stimulus(0, 3'b111, {8'h33, 8'hA5, 8'h11});
        step();
        rst_n = 1'b1;
        q_a.push_back('{id: 2'd0, data: 8'h11});
        q_a.push_back('{id: 2'd1, data: 8'hA5});
        q_a.push_back('{id: 2'd2, data: 8'h33});
        q_a.push_back('{id: 2'd0, data: 8'h11});
        for (int f = 0; f < 4; f++) begin
            wait_start(0, 10, $sformatf("t2_start_%0d", f));
            if (f == 3) apply_stimulus(0, 3'b000, {8'h33, 8'hA5, 8'h11});
            step();
            pulse_done(0);
            give_ticks(16);
        end
        check_output("t2_idle_end", 32'(busy_a), 32'd0);

        // Timeout on the 4th tick in SEND, then a 2-tick guard.
        apply_stimulus(1, 3'b100, {8'hC3, 8'h00, 8'h5A});
        q_b.push_back('{id: 2'd2, data: 8'hC3});
        wait_start(1, 10, "t3_start_seen");
        apply_stimulus(1, 3'b000, {8'hC3, 8'h00, 8'h5A});
        step();
        give_ticks(3);
        check_output("t3_no_timeout_3", 32'(to_b), 32'd0);
        give_ticks(1);
        check_output("t3_timeout_pulse", 32'(to_b), 32'd1);
        step();
        check_output("t3_timeout_cleared", 32'(to_b), 32'd0);
        check_output("t3_busy_guard", 32'(busy_b), 32'd1);
        give_ticks(1);
        check_output("t3_busy_guard1", 32'(busy_b), 32'd1);
        give_ticks(1);
        check_output("t3_idle", 32'(busy_b), 32'd0);

        // Done together with the 4th tick: done wins, no timeout.
        apply_stimulus(1, 3'b001, {8'hC3, 8'h00, 8'h5A});
        q_b.push_back('{id: 2'd0, data: 8'h5A});
        wait_start(1, 10, "t4_start_seen");
        apply_stimulus(1, 3'b000, {8'hC3, 8'h00, 8'h5A});
        step();
        give_ticks(3);
        tick   = 1'b1;
        done_b = 1'b1;
        step();
        tick   = 1'b0;
        done_b = 1'b0;
        check_output("t4_no_timeout", 32'(to_b), 32'd0);
        check_output("t4_busy_guard", 32'(busy_b), 32'd1);
        give_ticks(1);
        check_output("t4_busy_guard1", 32'(busy_b), 32'd1);
        give_ticks(1);
        check_output("t4_idle", 32'(busy_b), 32'd0);

        // Reset dropped mid-SEND, then requester 2 alone.
        apply_stimulus(0, 3'b001, {8'h33, 8'hA5, 8'h11});
        q_a.push_back('{id: 2'd0, data: 8'h11});
        wait_start(0, 10, "t5_start_seen");
        apply_stimulus(0, 3'b000, {8'h33, 8'hA5, 8'h11});
        step();
        check_output("t5_busy_send", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("t5_rst_busy",   32'(busy_a),  32'd0);
        check_output("t5_rst_txdata", 32'(txd_a),   32'd0);
        check_output("t5_rst_grant",  32'(gid_a),   32'd0);
        step();
        rst_n = 1'b1;
        apply_stimulus(0, 3'b100, {8'h33, 8'hA5, 8'h11});
        q_a.push_back('{id: 2'd2, data: 8'h33});
        wait_start(0, 10, "t5_start_after_reset");
        check_output("t5_grant2", 32'(gid_a), 32'd2);
        apply_stimulus(0, 3'b000, {8'h33, 8'hA5, 8'h11});
        step();
        pulse_done(0);
        give_ticks(16);
        check_output("t5_idle", 32'(busy_a), 32'd0);

        // Zero guard: IDLE right after done, back-to-back starts 3 cycles apart.
        apply_stimulus(2, 3'b011, {8'h00, 8'h22, 8'h44});
        q_c.push_back('{id: 2'd0, data: 8'h44});
        q_c.push_back('{id: 2'd1, data: 8'h22});
        wait_start(2, 10, "t6_first_start");
        t1 = cyc;
        step();
        pulse_done(2);
        check_output("t6_idle_after_done", 32'(busy_c), 32'd0);
        step();
        check_output("t6_second_start", 32'(start_c), 32'd1);
        check_output("t6_start_spacing", 32'(cyc - t1), 32'd3);
        apply_stimulus(2, 3'b000, {8'h00, 8'h22, 8'h44});
        step();
        pulse_done(2);
        check_output("t6_idle_end", 32'(busy_c), 32'd0);

        repeat (3) step();
        check_output("a_queue_empty", 32'(q_a.size()), 32'd0);
        check_output("b_queue_empty", 32'(q_b.size()), 32'd0);
        check_output("c_queue_empty", 32'(q_c.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
